// File: rtl/blockade_pkg.sv
// Shared definitions for the Blockade host-side ioctl blocks.
package blockade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAUSE,
        READY,
        READ
    } state_t;

    localparam int          IOCTL_ADDR_W = 25;
    localparam logic [7:0]  IDX_ROM      = 8'd0;
    localparam logic [7:0]  IDX_UPLOAD   = 8'd4;

endpackage

// File: rtl/blockade_upload.sv
// Upload responder: pauses the game CPU and serves work-RAM bytes to the host
// over the ioctl bus, stretching each read with ioctl_wait until data is valid.
module blockade_upload
    import blockade_pkg::*;
#(
    parameter logic [7:0] UPLOAD_INDEX = IDX_UPLOAD,
    parameter int         RAM_AW       = 10,
    parameter int         RAM_SIZE     = 1024,
    parameter int         RAM_LATENCY  = 1,
    parameter logic [7:0] FILL         = 8'hFF
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ioctl_upload,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_rd,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    output logic [7:0]              ioctl_din,
    output logic                    ioctl_wait,
    output logic                    pause_req,
    input  logic                    pause_ack,
    output logic [RAM_AW-1:0]       ram_addr,
    output logic                    ram_rd,
    input  logic [7:0]              ram_data,
    output logic                    proto_err
);

    localparam logic [IOCTL_ADDR_W-1:0] RAM_LIMIT = IOCTL_ADDR_W'(RAM_SIZE);
    localparam logic [2:0]              LAT_INIT  = 3'(RAM_LATENCY);

    state_t            state_q;
    logic              start;
    logic              start_q;
    logic [7:0]        din_q;
    logic              wait_q;
    logic              pause_req_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              ram_rd_q;
    logic              proto_err_q;
    logic [2:0]        cnt_q;

    assign start = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

    // start_q comes out of reset high so a session already running at reset
    // release is ignored until it drops and is raised again.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b1;
            din_q       <= 8'h00;
            wait_q      <= 1'b0;
            pause_req_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            proto_err_q <= 1'b0;
            cnt_q       <= 3'd0;
        end else begin
            start_q  <= start;
            ram_rd_q <= 1'b0;
            if (ioctl_rd && wait_q) begin
                proto_err_q <= 1'b1;
            end
            // Session end beats everything else, including a same-cycle read.
            if (state_q != IDLE && !start) begin
                state_q     <= IDLE;
                pause_req_q <= 1'b0;
                wait_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !start_q) begin
                            pause_req_q <= 1'b1;
                            wait_q      <= 1'b1;
                            state_q     <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (pause_ack) begin
                            wait_q  <= 1'b0;
                            state_q <= READY;
                        end
                    end
                    READY: begin
                        if (ioctl_rd) begin
                            if (ioctl_addr < RAM_LIMIT) begin
                                ram_addr_q <= ioctl_addr[RAM_AW-1:0];
                                ram_rd_q   <= 1'b1;
                                wait_q     <= 1'b1;
                                cnt_q      <= LAT_INIT;
                                state_q    <= READ;
                            end else begin
                                din_q <= FILL;
                            end
                        end
                    end
                    READ: begin
                        // Counter reaches zero on the edge the RAM data is valid.
                        if (cnt_q == 3'd0) begin
                            din_q   <= ram_data;
                            wait_q  <= 1'b0;
                            state_q <= READY;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign pause_req  = pause_req_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_blockade_upload.sv
// Bench for blockade_upload: two instances (RAM latency 1 and 3) share the host
// stimulus; each has its own RAM model and expected-byte queue.
module tb_blockade_upload;

    logic        clk = 1'b0;
    logic        rst;
    logic        upload;
    logic [7:0]  index;
    logic        rd;
    logic [24:0] addr;
    logic        pack;

    logic [7:0]  din1, din3, rdata1, rdata3;
    logic        wait1, wait3, pr1, pr3, rrd1, rrd3, perr1, perr3;
    logic [9:0]  raddr1, raddr3;

    logic [7:0]  mem [0:1023];
    logic [7:0]  exp_q1[$];
    logic [7:0]  exp_q3[$];
    logic [7:0]  last_din;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    blockade_upload #(.RAM_LATENCY(1)) dut1 (
        .clk_sys(clk), .reset(rst), .ioctl_upload(upload), .ioctl_index(index),
        .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din1), .ioctl_wait(wait1),
        .pause_req(pr1), .pause_ack(pack), .ram_addr(raddr1), .ram_rd(rrd1),
        .ram_data(rdata1), .proto_err(perr1)
    );

    blockade_upload #(.RAM_LATENCY(3)) dut3 (
        .clk_sys(clk), .reset(rst), .ioctl_upload(upload), .ioctl_index(index),
        .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din3), .ioctl_wait(wait3),
        .pause_req(pr3), .pause_ack(pack), .ram_addr(raddr3), .ram_rd(rrd3),
        .ram_data(rdata3), .proto_err(perr3)
    );

    // RAM models: data is driven only in the single cycle it is valid.
    logic       v1;
    logic [9:0] a1;
    logic       v3 [0:2];
    logic [9:0] a3 [0:2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; a1 <= '0;
            for (int i = 0; i < 3; i++) begin v3[i] <= 1'b0; a3[i] <= '0; end
        end else begin
            v1 <= rrd1; a1 <= raddr1;
            v3[0] <= rrd3; a3[0] <= raddr3;
            v3[1] <= v3[0]; a3[1] <= a3[0];
            v3[2] <= v3[1]; a3[2] <= a3[1];
        end
    end

    assign rdata1 = v1    ? mem[a1]    : 8'h00;
    assign rdata3 = v3[2] ? mem[a3[2]] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_din1"}, din1, 0);   chk({tag, "_din3"}, din3, 0);
        chk({tag, "_wait1"}, wait1, 0); chk({tag, "_wait3"}, wait3, 0);
        chk({tag, "_pr1"}, pr1, 0);     chk({tag, "_pr3"}, pr3, 0);
        chk({tag, "_rrd1"}, rrd1, 0);   chk({tag, "_rrd3"}, rrd3, 0);
        chk({tag, "_raddr1"}, raddr1, 0); chk({tag, "_raddr3"}, raddr3, 0);
        chk({tag, "_perr1"}, perr1, 0); chk({tag, "_perr3"}, perr3, 0);
    endtask

    task automatic pop_chk(input string tag, input int which, input logic [7:0] obs);
        logic [7:0] e;
        e = 8'hxx;
        if (which == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
        if (which == 3 && exp_q3.size() > 0) e = exp_q3.pop_front();
        chk(tag, obs, e);
        last_din = e;
    endtask

    // In-range read; dup repeats ioctl_rd one cycle into the wait window.
    task automatic do_read(input logic [24:0] a, input bit dup);
        int w1, w3, r1, r3;
        bit done1, done3;
        exp_q1.push_back(mem[a[9:0]]);
        exp_q3.push_back(mem[a[9:0]]);
        rd = 1'b1; addr = a;
        tick();
        chk("rd_pulse1", rrd1, 1);      chk("rd_pulse3", rrd3, 1);
        chk("rd_addr1", raddr1, a[9:0]); chk("rd_addr3", raddr3, a[9:0]);
        chk("wait_rise1", wait1, 1);    chk("wait_rise3", wait3, 1);
        w1 = 1; w3 = 1; r1 = 1; r3 = 1; done1 = 0; done3 = 0;
        if (dup) addr = a ^ 25'h10;
        else rd = 1'b0;
        for (int c = 0; c < 12 && !(done1 && done3); c++) begin
            tick();
            rd = 1'b0;
            if (!done1) begin
                r1 += int'(rrd1);
                if (wait1) w1++;
                else begin done1 = 1; pop_chk("rd_din1", 1, din1); end
            end
            if (!done3) begin
                r3 += int'(rrd3);
                if (wait3) w3++;
                else begin done3 = 1; pop_chk("rd_din3", 3, din3); end
            end
        end
        chk("wait_len1", w1, 2); chk("wait_len3", w3, 4);
        chk("rd_cnt1", r1, 1);   chk("rd_cnt3", r3, 1);
    endtask

    task automatic do_oor(input logic [24:0] a);
        exp_q1.push_back(8'hFF);
        exp_q3.push_back(8'hFF);
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
        chk("oor_wait1", wait1, 0); chk("oor_wait3", wait3, 0);
        chk("oor_rrd1", rrd1, 0);   chk("oor_rrd3", rrd3, 0);
        pop_chk("oor_din1", 1, din1);
        pop_chk("oor_din3", 3, din3);
        tick();
        chk("oor_hold1", din1, 8'hFF); chk("oor_hold3", din3, 8'hFF);
        chk("oor_wait1b", wait1, 0);   chk("oor_wait3b", wait3, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
        mem[10'h012] = 8'hA5;
        rst = 1'b1; upload = 1'b0; index = 8'd0; rd = 1'b0; addr = '0; pack = 1'b0;
        last_din = 8'h00;
        tick(); tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Wrong index: nothing happens.
        upload = 1'b1; index = 8'd0;
        tick();
        rd = 1'b1; addr = 25'h012;
        tick();
        rd = 1'b0;
        chk("widx_pr1", pr1, 0);    chk("widx_pr3", pr3, 0);
        chk("widx_wait1", wait1, 0); chk("widx_rrd1", rrd1, 0);
        tick();
        chk("widx_din1", din1, 0);  chk("widx_din3", din3, 0);
        upload = 1'b0;
        tick();

        // Start handshake with pause_ack held low for 5 cycles.
        upload = 1'b1; index = 8'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hs_pr1", pr1, 1);     chk("hs_pr3", pr3, 1);
            chk("hs_wait1", wait1, 1); chk("hs_wait3", wait3, 1);
        end
        pack = 1'b1;
        tick();
        chk("hs_ack_wait1", wait1, 0); chk("hs_ack_wait3", wait3, 0);
        chk("hs_ack_pr1", pr1, 1);     chk("hs_ack_pr3", pr3, 1);

        // Reads; pause_ack dropping mid-session must not matter.
        do_read(25'h012, 0);
        pack = 1'b0;
        do_oor(25'h400);
        do_read(25'h3FF, 0);
        do_oor(25'h1000012);
        do_read(25'h000, 0);
        chk("perr_pre1", perr1, 0); chk("perr_pre3", perr3, 0);

        // Protocol violation: extra ioctl_rd during READ.
        do_read(25'h020, 1);
        chk("perr1", perr1, 1); chk("perr3", perr3, 1);
        chk("pr_still1", pr1, 1);

        // Abort one cycle after the read is issued.
        rd = 1'b1; addr = 25'h040;
        tick();
        rd = 1'b0; upload = 1'b0;
        tick();
        chk("abort_wait1", wait1, 0); chk("abort_wait3", wait3, 0);
        chk("abort_pr1", pr1, 0);     chk("abort_pr3", pr3, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_din1", din1, last_din); chk("abort_din3", din3, last_din);
        chk("abort_wait1b", wait1, 0);

        // Restart, then abort in the same cycle as ioctl_rd.
        pack = 1'b1; upload = 1'b1;
        tick(); tick();
        chk("re_wait1", wait1, 0); chk("re_pr3", pr3, 1);
        rd = 1'b1; addr = 25'h012; upload = 1'b0;
        tick();
        rd = 1'b0;
        chk("sim_rrd1", rrd1, 0);  chk("sim_rrd3", rrd3, 0);
        chk("sim_wait1", wait1, 0); chk("sim_pr1", pr1, 0);
        tick(); tick();
        chk("sim_din1", din1, last_din); chk("sim_din3", din3, last_din);

        // Asynchronous reset in the middle of a read.
        upload = 1'b1;
        tick(); tick();
        rd = 1'b1; addr = 25'h055;
        tick();
        rd = 1'b0; pack = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        tick();
        rst = 1'b0;

        // Session active across reset release must not start.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_pr1", pr1, 0); chk("held_pr3", pr3, 0);
        end
        upload = 1'b0;
        tick();
        upload = 1'b1;
        tick();
        chk("rearm_pr1", pr1, 1);     chk("rearm_pr3", pr3, 1);
        chk("rearm_wait1", wait1, 1); chk("rearm_wait3", wait3, 1);

        chk("q1_empty", exp_q1.size(), 0);
        chk("q3_empty", exp_q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blockade_upload.md
Name: blockade_upload

Overview:
- Host-side upload responder for the Blockade core; the read-back counterpart of the ROM download path (dn_addr/dn_data/dn_wr).
- While the HPS runs an upload (ioctl_upload with the matching ioctl_index), it pauses the game CPU, then serves bytes from game work RAM (high-score/NVRAM region) on ioctl_din.
- It stretches each host read with ioctl_wait until the RAM data is valid.
- Sits between the ioctl bus in emu and a spare read port of the blockade work RAM.

Parameters:
- UPLOAD_INDEX, 8'd4, ioctl_index value that selects this responder.
- RAM_AW, 10, work-RAM address width.
- RAM_SIZE, 1024, number of readable bytes; host addresses >= RAM_SIZE are out of range.
- RAM_LATENCY, 1, cycles from ram_rd sampled by the RAM to ram_data valid (1..7).
- FILL, 8'hFF, byte returned for out-of-range addresses.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- ioctl_upload  in  1  host upload session active (level)
- ioctl_index  in  8  upload target selector
- ioctl_rd  in  1  host read strobe, one cycle per byte
- ioctl_addr  in  25  host byte address, valid with ioctl_rd
- ioctl_din  out  8  byte returned to host
- ioctl_wait  out  1  host must stall while high
- pause_req  out  1  request CPU pause
- pause_ack  in  1  CPU paused, bus quiescent
- ram_addr  out  RAM_AW  work-RAM read address
- ram_rd  out  1  work-RAM read strobe, one cycle
- ram_data  in  8  work-RAM read data
- proto_err  out  1  sticky: ioctl_rd seen while ioctl_wait high

Behaviour:
- Clock and reset: one clock (clk_sys). Asynchronous active-high reset sets ioctl_din=0, ioctl_wait=0, pause_req=0, ram_rd=0, ram_addr=0, proto_err=0, latency counter=0 and state=IDLE.
- Session start (start = ioctl_upload && ioctl_index==UPLOAD_INDEX, registered for edge detection):
  - IDLE: on the rising edge of start, set pause_req=1 and ioctl_wait=1, then go to PAUSE.
  - A session already active when reset releases is not started until start falls and rises again.
- PAUSE: when pause_ack=1, clear ioctl_wait and go to READY. pause_req stays high until the session ends.
- READY, on ioctl_rd=1 at clock edge N:
  - If ioctl_addr < RAM_SIZE (full 25-bit compare): at edge N set ram_addr=ioctl_addr[RAM_AW-1:0], ram_rd=1 (exactly one cycle), ioctl_wait=1, and counter=RAM_LATENCY. Go to READ.
  - Otherwise: at edge N set ioctl_din=FILL. No wait and no RAM access. Stay in READY.
- READ:
  - Counter decrements each cycle.
  - At edge N+1+RAM_LATENCY, ioctl_din=ram_data and ioctl_wait=0, then go to READY.
  - ioctl_wait is therefore high for exactly RAM_LATENCY+1 cycles per in-range read.
- ioctl_din holds its value between reads and after the session ends.
- Protocol violation: ioctl_rd while ioctl_wait=1 (PAUSE or READ) is ignored for data and sets proto_err. proto_err clears only on reset.
- Session end: start falling in any state returns to IDLE on the next edge with pause_req=0, ioctl_wait=0 and ram_rd=0. A RAM read in flight is abandoned and ioctl_din is not updated.
- Simultaneous events: start falling in the same cycle as ioctl_rd means the abort wins and no read is issued. pause_ack falling during a session has no effect.
- ram_addr holds its value when ram_rd=0.

Decomposition:
- Shared package blockade_pkg holds:
  - the state enum (IDLE, PAUSE, READY, READ);
  - IOCTL_ADDR_W=25;
  - ioctl index constants (ROM=0, UPLOAD=4).
- No sub-module; a single FSM plus a 3-bit latency counter fits in one file.
- The RAM model lives in the testbench only.

Test Plan:
- Start handshake: raise ioctl_upload with index 4 and hold pause_ack low for 5 cycles -> pause_req=1 and ioctl_wait=1 for those cycles. Raise pause_ack -> ioctl_wait=0 on the next edge.
- In-range read, RAM_LATENCY=1, RAM[0x012]=0xA5: ioctl_rd with addr 0x012 -> ram_rd for one cycle with ram_addr=0x012, ioctl_wait high for 2 cycles, then ioctl_din=0xA5.
- Out-of-range read: addr 0x400 -> ioctl_din=0xFF on the next edge, ioctl_wait never rises, ram_rd stays 0.
- Wrong index: ioctl_upload with index 0 -> pause_req stays 0, ioctl_rd is ignored, ioctl_din is unchanged.
- Abort mid-read, RAM_LATENCY=3: drop ioctl_upload one cycle after ioctl_rd -> next edge gives IDLE, ioctl_wait=0, pause_req=0, and ioctl_din keeps its previous value.
- Protocol error and reset: ioctl_rd during READ -> proto_err=1 and the in-flight byte is still delivered. Assert reset mid-session -> all outputs return to 0 immediately (asynchronous reset).
